// File: rtl/reg8_pkg.sv
// Shared definitions for the 8x8 register-file controller: default widths,
// register count and write-FSM state encoding.
package reg8_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 3;
    localparam int NREG   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2
    } state_t;

endpackage

// File: rtl/reg8file_ctrl_btn_edge_sync.sv
// Button front end: two-flop synchronizer for an asynchronous level plus a
// previous-value flop, giving a one-cycle pulse on each rising edge.
module btn_edge_sync (
    input  logic clk,
    input  logic clr,
    input  logic btn,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;

endmodule

// File: rtl/reg8file_ctrl.sv
// Upstream controller for the 8x8 register file: button-driven single writes
// and 8-cycle fill bursts, manual or timed auto-scan read select, display latch.
module reg8file_ctrl
    import reg8_pkg::*;
#(
    parameter int TICK_DIV = 100_000,
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          btn_wr,
    input  logic          btn_fill,
    input  logic [DW-1:0] sw_data,
    input  logic [AW-1:0] sw_addr,
    input  logic          scan_en,
    input  logic [DW-1:0] q_in,
    output logic          en,
    output logic [AW-1:0] wsel,
    output logic [DW-1:0] d,
    output logic [AW-1:0] rsel,
    output logic [DW-1:0] disp_data,
    output logic [AW-1:0] disp_idx,
    output logic          busy
);

    // state | meaning
    // IDLE  | waiting for a button pulse, en=0
    // WRITE | single write cycle presented on en/wsel/d
    // FILL  | burst: wsel=cnt, d=base+cnt for cnt 0..NREG-1

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] CNT_LAST  = AW'(NREG - 1);

    logic          wr_pulse;
    logic          fill_pulse;
    state_t        state;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nxt;
    logic [DW-1:0] base;
    logic [TW-1:0] tick;

    btn_edge_sync u_sync_wr (
        .clk   (clk),
        .clr   (clr),
        .btn   (btn_wr),
        .pulse (wr_pulse)
    );

    btn_edge_sync u_sync_fill (
        .clk   (clk),
        .clr   (clr),
        .btn   (btn_fill),
        .pulse (fill_pulse)
    );

    assign cnt_nxt = cnt + 1'b1;

    // Pulses are only consumed in IDLE, so anything arriving while busy is dropped.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            en    <= 1'b0;
            wsel  <= '0;
            d     <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
            base  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fill_pulse) begin
                        state <= FILL;
                        base  <= sw_data;
                        cnt   <= '0;
                        en    <= 1'b1;
                        wsel  <= '0;
                        d     <= sw_data;
                        busy  <= 1'b1;
                    end else if (wr_pulse) begin
                        state <= WRITE;
                        en    <= 1'b1;
                        wsel  <= sw_addr;
                        d     <= sw_data;
                        busy  <= 1'b1;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                    en    <= 1'b0;
                    busy  <= 1'b0;
                end
                FILL: begin
                    if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        en    <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        cnt  <= cnt_nxt;
                        wsel <= cnt_nxt;
                        d    <= base + DW'(cnt_nxt);
                    end
                end
                default: begin
                    state <= IDLE;
                    en    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Scan keeps rsel when enabled, so resuming continues from the manual address.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tick <= '0;
            rsel <= '0;
        end else if (scan_en) begin
            if (tick == TICK_LAST) begin
                tick <= '0;
                rsel <= rsel + 1'b1;
            end else begin
                tick <= tick + 1'b1;
            end
        end else begin
            tick <= '0;
            rsel <= sw_addr;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            disp_data <= '0;
            disp_idx  <= '0;
        end else begin
            disp_data <= q_in;
            disp_idx  <= rsel;
        end
    end

endmodule

// File: tb/tb_reg8file_ctrl.sv
// Scoreboard bench for reg8file_ctrl with a behavioural 8x8 register file
// attached downstream; write and display expectations are queued and popped by monitors.
module tb_reg8file_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic       btn_wr;
    logic       btn_fill;
    logic [7:0] sw_data;
    logic [2:0] sw_addr;
    logic       scan_en;
    logic [7:0] q_in;
    logic       en;
    logic [2:0] wsel;
    logic [7:0] d;
    logic [2:0] rsel;
    logic [7:0] disp_data;
    logic [2:0] disp_idx;
    logic       busy;

    logic [7:0] regs [8];

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] dat;
    } pair_t;

    pair_t wr_q[$];
    pair_t disp_q[$];

    int   checks = 0;
    int   errors = 0;
    int   run_len = 0;
    logic disp_mon = 1'b0;
    logic [2:0] prev_idx;
    int   gap;
    logic gap_valid;

    always #5 clk = ~clk;

    reg8file_ctrl #(.TICK_DIV(4), .DW(8), .AW(3)) dut (
        .clk       (clk),
        .clr       (clr),
        .btn_wr    (btn_wr),
        .btn_fill  (btn_fill),
        .sw_data   (sw_data),
        .sw_addr   (sw_addr),
        .scan_en   (scan_en),
        .q_in      (q_in),
        .en        (en),
        .wsel      (wsel),
        .d         (d),
        .rsel      (rsel),
        .disp_data (disp_data),
        .disp_idx  (disp_idx),
        .busy      (busy)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
        end else if (en) begin
            regs[wsel] <= d;
        end
    end

    assign q_in = regs[rsel];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_fill(input logic [7:0] b);
        for (int i = 0; i < 8; i++) wr_q.push_back({3'(i), 8'(b + 8'(i))});
    endtask

    // Write monitor: every en cycle must match the next queued write.
    always @(negedge clk) begin
        pair_t w;
        if (!clr) begin
            if (en || busy) check("busy_matches_en", {31'd0, busy}, {31'd0, en});
            if (en) begin
                run_len++;
                if (run_len > 8) check("en_run_len", run_len, 8);
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual wsel=%0d d=%0h required no write", wsel, d);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_wsel", {29'd0, wsel}, {29'd0, w.sel});
                    check("wr_d", {24'd0, d}, {24'd0, w.dat});
                end
            end else begin
                run_len = 0;
            end
        end
    end

    // Display monitor: each change of disp_idx must match the next queued pair.
    always @(negedge clk) begin
        pair_t p;
        if (disp_mon) begin
            gap++;
            if (disp_idx != prev_idx) begin
                if (disp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_disp actual idx=%0d data=%0h required no change", disp_idx, disp_data);
                end else begin
                    p = disp_q.pop_front();
                    check("disp_idx", {29'd0, disp_idx}, {29'd0, p.sel});
                    check("disp_data", {24'd0, disp_data}, {24'd0, p.dat});
                end
                if (gap_valid) check("scan_period", gap, 4);
                gap_valid = 1'b1;
                gap       = 0;
                prev_idx  = disp_idx;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit seen;
        logic [7:0] scan_dat [9];
        logic [2:0] scan_idx [9];
        scan_idx = '{3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        scan_dat = '{8'h05, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

        clr = 1'b1; btn_wr = 1'b0; btn_fill = 1'b0;
        sw_data = 8'h00; sw_addr = 3'd0; scan_en = 1'b0;
        cycles(3);
        check("rst_en", {31'd0, en}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_wsel_d", {21'd0, wsel, d}, 0);
        check("rst_rsel_disp", {18'd0, rsel, disp_idx, disp_data}, 0);
        clr = 1'b0;
        cycles(3);

        // 1: reset in the middle of a fill burst
        sw_data = 8'h10;
        for (int i = 0; i < 4; i++) wr_q.push_back({3'(i), 8'(8'h10 + 8'(i))});
        btn_fill = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (en && wsel == 3'd3) seen = 1'b1;
        end
        check("fill_reached_cnt3", {31'd0, seen}, 1);
        #1 clr = 1'b1;
        #1;
        check("clr_en", {31'd0, en}, 0);
        check("clr_busy", {31'd0, busy}, 0);
        check("clr_wsel_d", {21'd0, wsel, d}, 0);
        check("clr_disp", {21'd0, disp_idx, disp_data}, 0);
        cycles(2);
        btn_fill = 1'b0;
        cycles(1);
        clr = 1'b0;
        cycles(20);
        for (int i = 3; i < 8; i++) check("no_write_after_clr", {24'd0, regs[i]}, 0);
        check("wr_q_empty_t1", wr_q.size(), 0);

        // 2: single write with a long button hold
        sw_addr = 3'd5; sw_data = 8'hA5;
        wr_q.push_back({3'd5, 8'hA5});
        btn_wr = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(negedge clk);
            if (en) lat = i;
        end
        check("wr_latency", lat, 3);
        cycles(20 - lat);
        btn_wr = 1'b0;
        cycles(5);
        check("manual_disp_idx", {29'd0, disp_idx}, 5);
        check("manual_disp_data", {24'd0, disp_data}, 32'hA5);
        check("wr_q_empty_t2", wr_q.size(), 0);

        // 4: simultaneous buttons -> fill only; wr during fill ignored
        sw_addr = 3'd2; sw_data = 8'h30;
        push_fill(8'h30);
        btn_wr = 1'b1; btn_fill = 1'b1;
        cycles(2);
        btn_wr = 1'b0; btn_fill = 1'b0;
        cycles(2);
        sw_addr = 3'd1; sw_data = 8'h77;
        btn_wr = 1'b1;
        cycles(2);
        btn_wr = 1'b0;
        cycles(14);
        check("wr_q_empty_t4", wr_q.size(), 0);

        // 3: fill with wrap of the data value
        sw_data = 8'hFE;
        push_fill(8'hFE);
        btn_fill = 1'b1;
        cycles(3);
        btn_fill = 1'b0;
        cycles(15);
        check("wr_q_empty_t3", wr_q.size(), 0);

        // 5: auto-scan from rsel=6, wrapping 7->0
        sw_addr = 3'd6;
        cycles(3);
        check("pre_scan_idx", {29'd0, disp_idx}, 6);
        for (int i = 0; i < 9; i++) disp_q.push_back({scan_idx[i], scan_dat[i]});
        prev_idx  = disp_idx;
        gap       = 0;
        gap_valid = 1'b0;
        disp_mon  = 1'b1;
        scan_en   = 1'b1;
        cycles(39);
        disp_mon  = 1'b0;
        check("disp_q_empty_t5", disp_q.size(), 0);
        check("wr_q_empty_end", wr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
